// File: rtl/multi_led_pattern.sv
// Multi-channel active-low LED pattern generator: off / solid / blink / breathe per channel.
// Optional macro BREATHE_EN builds the triangle-wave PWM breathe mode; without it mode 11 blinks.

module multi_led_lane #(
  parameter int BLINK_TICKS = 128
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic       tick_i,
  input  logic       pwm_on,
  input  logic [1:0] mode,
  output logic       led_n
);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_TICKS - 1);

  logic [1:0]    mode_q;
  logic [BW-1:0] bcnt;
  logic          phase;
  logic          on;

  always_comb begin
    on = 1'b0;
    unique case (mode_q)
      2'b00: on = 1'b0;
      2'b01: on = 1'b1;
      2'b10: on = phase;
`ifdef BREATHE_EN
      2'b11: on = pwm_on;
`else
      2'b11: on = phase;
`endif
    endcase
  end

`ifndef BREATHE_EN
  logic unused_pwm_on;
  assign unused_pwm_on = pwm_on;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q <= 2'b00;
      bcnt   <= '0;
      phase  <= 1'b1;
      led_n  <= 1'b1;
    end else begin
      mode_q <= mode;
      led_n  <= ~(EN & on);
      // a mode rewrite restarts the blink and beats a coincident tick
      if (mode != mode_q) begin
        bcnt  <= '0;
        phase <= 1'b1;
      end else if (tick_i) begin
        if (bcnt == BCNT_MAX) begin
          bcnt  <= '0;
          phase <= ~phase;
        end else begin
          bcnt <= bcnt + BW'(1);
        end
      end
    end
  end
endmodule

module multi_led_pattern #(
  parameter int N_CH        = 2,
  parameter int TICK_DIV    = 46875,
  parameter int BLINK_TICKS = 128
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic [2*N_CH-1:0] MODE,
  output logic [N_CH-1:0]   LED_N,
  output logic              TICK
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_cnt;
  logic [7:0]    pwm_cnt;
  logic          tick_i;
  logic          pwm_on;

  assign tick_i = EN & (pre_cnt == PRE_MAX);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_cnt <= '0;
      pwm_cnt <= 8'd0;
      TICK    <= 1'b0;
    end else begin
      TICK <= tick_i;
      if (EN) begin
        pre_cnt <= tick_i ? '0 : pre_cnt + PW'(1);
        pwm_cnt <= pwm_cnt + 8'd1;
      end
    end
  end

`ifdef BREATHE_EN
  logic [7:0] lvl;
  logic       dir_dn;

  // triangle wave: saturate one tick at each end before reversing
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lvl    <= 8'd0;
      dir_dn <= 1'b0;
    end else if (tick_i) begin
      if (!dir_dn) begin
        if (lvl == 8'hFF) dir_dn <= 1'b1;
        else              lvl    <= lvl + 8'd1;
      end else begin
        if (lvl == 8'h00) dir_dn <= 1'b0;
        else              lvl    <= lvl - 8'd1;
      end
    end
  end

  assign pwm_on = (pwm_cnt < lvl);
`else
  logic unused_pwm;
  assign pwm_on     = 1'b0;
  assign unused_pwm = ^pwm_cnt;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    multi_led_lane #(.BLINK_TICKS(BLINK_TICKS)) u_lane (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .EN     (EN),
      .tick_i (tick_i),
      .pwm_on (pwm_on),
      .mode   (MODE[2*g +: 2]),
      .led_n  (LED_N[g])
    );
  end
endmodule

// File: tb/tb_multi_led_pattern.sv
// Bench for multi_led_pattern: hand tables, corner sequences and a time-based reference model.
module tb_multi_led_pattern;
  localparam int NC = 2;
  localparam int TD = 4;
  localparam int BT = 2;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          EN = 1'b0;
  logic [3:0]    MODE = 4'b0000;
  logic [NC-1:0] LED_N;
  logic          TICK;

  multi_led_pattern #(.N_CH(NC), .TICK_DIV(TD), .BLINK_TICKS(BT)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .LED_N(LED_N), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  int ntests = 0;
  int nfail  = 0;

  // model: everything is derived from the count of enabled cycles
  int       en_cyc;
  int       start[NC];
  logic [1:0] mq[NC];
  logic [1:0] m_led;
  bit         m_tick;

  typedef struct {
    bit         en;
    logic [3:0] mode;
    logic [1:0] led;
    bit         tick;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int lvl_of(input int ticks);
    int k;
    k = ticks % 512;
    return (k < 256) ? k : 511 - k;
  endfunction

  function automatic void model_reset();
    en_cyc = 0;
    for (int c = 0; c < NC; c++) begin
      start[c] = 0;
      mq[c] = 2'b00;
    end
  endfunction

  // one clock: predict, drive at negedge, sample 1 after posedge, advance model
  task automatic step(input bit en, input logic [3:0] mode);
    int ticks;
    bit on, ph;
    ticks = en_cyc / TD;
    m_tick = en && ((en_cyc % TD) == TD - 1);
    for (int c = 0; c < NC; c++) begin
      ph = (((ticks - start[c]) / BT) % 2) == 0;
      case (mq[c])
        2'b00: on = 1'b0;
        2'b01: on = 1'b1;
        2'b10: on = ph;
`ifdef BREATHE_EN
        default: on = (en_cyc % 256) < lvl_of(ticks);
`else
        default: on = ph;
`endif
      endcase
      m_led[c] = !(en && on);
    end
    @(negedge CLK);
    EN = en;
    MODE = mode;
    @(posedge CLK);
    #1;
    if (en) en_cyc++;
    ticks = en_cyc / TD;
    for (int c = 0; c < NC; c++) begin
      if (mode[2*c +: 2] != mq[c]) begin
        start[c] = ticks;
        mq[c] = mode[2*c +: 2];
      end
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    EN = 1'b1;
    MODE = 4'b0101;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_led", LED_N, 3);
    chk("rst_tick", TICK, 0);
    RST_N = 1'b1;
    model_reset();
  endtask

  task automatic rep(input int n, input bit en, input logic [3:0] mode,
                     input logic [1:0] led, input bit tick);
    vec_t v;
    v.en = en; v.mode = mode; v.led = led; v.tick = tick;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic run_table(input bit map11);
    logic [3:0] m;
    foreach (tbl[i]) begin
      m = tbl[i].mode;
      if (map11 && m[1:0] == 2'b10) m[1:0] = 2'b11;
      step(tbl[i].en, m);
      chk("tbl_led", LED_N, tbl[i].led);
      chk("tbl_tick", TICK, tbl[i].tick);
    end
  endtask

  initial begin
    int cnt, exp_cnt;
    bit en;
    logic [3:0] mode;

    // blink from reset, ch0 blink / ch1 solid; solid gap then blink rewrite on a toggle tick
    rep(1, 1, 4'b0110, 2'b11, 0);
    rep(2, 1, 4'b0110, 2'b00, 0); rep(1, 1, 4'b0110, 2'b00, 1);
    rep(3, 1, 4'b0110, 2'b00, 0); rep(1, 1, 4'b0110, 2'b00, 1);
    rep(3, 1, 4'b0110, 2'b01, 0); rep(1, 1, 4'b0110, 2'b01, 1);
    rep(3, 1, 4'b0110, 2'b01, 0); rep(1, 1, 4'b0110, 2'b01, 1);
    rep(3, 1, 4'b0101, 2'b00, 0); rep(1, 1, 4'b0101, 2'b00, 1);
    rep(3, 1, 4'b0101, 2'b00, 0); rep(1, 1, 4'b0110, 2'b00, 1);
    rep(3, 1, 4'b0110, 2'b00, 0); rep(1, 1, 4'b0110, 2'b00, 1);
    rep(3, 1, 4'b0110, 2'b00, 0); rep(1, 1, 4'b0110, 2'b00, 1);
    rep(1, 1, 4'b0110, 2'b01, 0);

    // reset release and asynchronous assertion
    do_reset();
    step(1, 4'b0101);
    chk("rel_e1_led", LED_N, 3);
    step(1, 4'b0101);
    chk("rel_e2_led", LED_N, 0);
    repeat (3) step(1, 4'b0101);
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst_led", LED_N, 3);
    chk("async_rst_tick", TICK, 0);

    // EN drop on a would-be tick, hold, then resume
    do_reset();
    repeat (7) step(1, 4'b0101);
    step(0, 4'b0101);
    chk("en_drop_tick", TICK, 0);
    chk("en_drop_led", LED_N, 3);
    repeat (3) begin
      step(0, 4'b0101);
      chk("en_hold_tick", TICK, 0);
    end
    step(1, 4'b0101); chk("en_resume_t1", TICK, 1);
    step(1, 4'b0101); chk("en_resume_t2", TICK, 0);
    step(1, 4'b0101); chk("en_resume_t3", TICK, 0);
    step(1, 4'b0101); chk("en_resume_t4", TICK, 0);
    step(1, 4'b0101); chk("en_resume_t5", TICK, 1);

    do_reset();
    run_table(1'b0);
`ifndef BREATHE_EN
    do_reset();
    run_table(1'b1);
`endif

`ifdef BREATHE_EN
    // breathe through a full triangle; duty window around lvl=64
    do_reset();
    cnt = 0;
    exp_cnt = 0;
    for (int p = 0; p < 256; p++) if (p < 64 + p / 4) exp_cnt++;
    for (int i = 0; i < 2200; i++) begin
      step(1, 4'b0011);
      chk("brth_led", LED_N, m_led);
      if (i >= 256 && i < 512 && LED_N[0] == 1'b0) cnt++;
    end
    chk("brth_window", cnt, exp_cnt);
`endif

    // random enable/mode traffic against the model
    do_reset();
    mode = 4'b0101;
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if (en && $urandom_range(0, 15) == 0) mode = 4'($urandom_range(0, 15));
      step(en, mode);
      chk("rnd_led", LED_N, m_led);
      chk("rnd_tick", TICK, m_tick);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
